// File: rtl/gray2bin_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gray2bin_pkg                                                     |
// | Brief   : Shared types, default sizes and Gray-to-binary helper.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package gray2bin_pkg;

  localparam int c_NREQ_DEF   = 4;
  localparam int c_W_DEF      = 4;
  localparam int c_CONV_MAXW  = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // MSB-first running XOR; zero-extended inputs convert correctly at any width.
  function automatic logic [c_CONV_MAXW-1:0] conv(input logic [c_CONV_MAXW-1:0] g);
    logic [c_CONV_MAXW-1:0] b;
    logic                   acc;
    acc = 1'b0;
    b   = '0;
    for (int i = c_CONV_MAXW - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gray2bin_core                                                    |
// | Brief   : Combinational W-bit Gray-to-binary converter.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module gray2bin_core
  import gray2bin_pkg::*;
#(
  parameter int W = c_W_DEF
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o = W'(conv(c_CONV_MAXW'(gray_i)));

endmodule
`default_nettype wire

// File: rtl/gray2bin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gray2bin_arbiter                                                 |
// | Brief   : Round-robin shared Gray-to-binary converter with valid/ready.    |
// |           Define GRAY_CHECK_EN to flag multi-bit Gray jumps on rsp_err.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module gray2bin_arbiter
  import gray2bin_pkg::*;
#(
  parameter int NREQ = c_NREQ_DEF,
  parameter int W    = c_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_gray,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [W-1:0]             rsp_bin,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
  input  logic                     rsp_ready
);

  localparam int IDW  = $clog2(NREQ);
  localparam int IDXW = IDW + 1;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             w_win_any;
  logic [IDW-1:0]   w_win_id;
  logic [IDXW-1:0]  w_idx;
  logic [W-1:0]     w_win_gray;
  logic [W-1:0]     w_win_bin;

  // Rotating search starting at rr_ptr; the extra index bit absorbs the wrap.
  always_comb begin
    w_win_any = 1'b0;
    w_win_id  = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, rr_ptr_q} + IDXW'(k);
      if (w_idx >= IDXW'(NREQ)) begin
        w_idx = w_idx - IDXW'(NREQ);
      end
      if (!w_win_any && req_valid[w_idx[IDW-1:0]]) begin
        w_win_any = 1'b1;
        w_win_id  = w_idx[IDW-1:0];
      end
    end
  end

  assign w_win_gray = req_gray[w_win_id*W +: W];

  gray2bin_core #(
    .W      (W)
  ) u_core (
    .gray_i (w_win_gray),
    .bin_o  (w_win_bin)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    bin_d     = bin_q;
    id_d      = id_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (w_win_any && !rst) begin
          req_ready[w_win_id] = 1'b1;
          bin_d    = w_win_bin;
          id_d     = w_win_id;
          rr_ptr_d = (w_win_id == IDW'(NREQ - 1)) ? '0 : w_win_id + IDW'(1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      bin_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      bin_q    <= bin_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid = (state_q == BUSY);
  assign rsp_bin   = bin_q;
  assign rsp_id    = id_q;

`ifdef GRAY_CHECK_EN
  logic [W-1:0]    last_gray_q [NREQ];
  logic [NREQ-1:0] seen_q;
  logic            err_q, err_d;
  logic            w_grant;
  logic [W-1:0]    w_diff;
  int              w_nflip;

  assign w_grant = |req_ready;

  // A repeated code is legal; only jumps of two or more bits are flagged.
  always_comb begin
    err_d   = err_q;
    w_diff  = last_gray_q[w_win_id] ^ w_win_gray;
    w_nflip = 0;
    for (int i = 0; i < W; i++) begin
      w_nflip = w_nflip + int'(w_diff[i]);
    end
    if (w_grant) begin
      err_d = seen_q[w_win_id] && (w_nflip > 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      seen_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        last_gray_q[i] <= '0;
      end
    end else begin
      err_q <= err_d;
      if (w_grant) begin
        last_gray_q[w_win_id] <= w_win_gray;
        seen_q[w_win_id]      <= 1'b1;
      end
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray2bin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_gray2bin_arbiter                                              |
// | Brief   : Directed vector table, round-robin sequence and random traffic.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gray2bin_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;
`ifdef GRAY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_gray;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [W-1:0]      rsp_bin;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              rsp_ready;

  always #5 clk = ~clk;

  gray2bin_arbiter #(
    .NREQ      (NREQ),
    .W         (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_bin   (rsp_bin),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  bit           m_busy;
  int           m_ptr;
  logic [W-1:0] m_bin;
  int           m_id;
  bit           m_err;
  logic [W-1:0] m_last [NREQ];
  bit           m_seen [NREQ];

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int k = 1; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    logic [W-1:0] g;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_bin = '0; m_id = 0; m_err = 0;
      for (int i = 0; i < NREQ; i++) begin m_last[i] = '0; m_seen[i] = 0; end
    end else if (!m_busy) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        g         = req_gray[w*W +: W];
        m_err     = CHK && m_seen[w] && ($countones(m_last[w] ^ g) > 1);
        m_last[w] = g;
        m_seen[w] = 1;
        m_bin     = g2b(g);
        m_id      = w;
        m_ptr     = (w + 1) % NREQ;
        m_busy    = 1;
      end
    end else if (rsp_ready) begin
      m_busy = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] g,
                       input logic rr, input logic r);
    req_valid = v; req_gray = g; rsp_ready = rr; rst = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic expect_cycle(input string name, input logic [NREQ-1:0] e_ready,
                              input logic e_valid, input logic [W-1:0] e_bin,
                              input logic [IDW-1:0] e_id, input logic e_err, input bit d);
    @(negedge clk);
    chk({name, ".ready"}, 32'(req_ready), 32'(e_ready));
    chk({name, ".valid"}, 32'(rsp_valid), 32'(e_valid));
    if (d) begin
      chk({name, ".bin"}, 32'(rsp_bin), 32'(e_bin));
      chk({name, ".id"},  32'(rsp_id),  32'(e_id));
      chk({name, ".err"}, 32'(rsp_err), 32'(e_err));
    end
    tick();
  endtask

  typedef struct {
    logic [NREQ-1:0]   v;
    logic [NREQ*W-1:0] g;
    logic              rr;
    logic              r;
    logic [NREQ-1:0]   e_ready;
    logic              e_valid;
    logic [W-1:0]      e_bin;
    logic [IDW-1:0]    e_id;
    logic              e_err;
    bit                d;
  } vec_t;

  vec_t tbl [25];

  initial begin
    logic [NREQ-1:0] v;
    logic [NREQ*W-1:0] g;
    logic [NREQ-1:0] e_ready;
    int w;
    int ord [6];
    logic [W-1:0] rr_bin [NREQ];

    tbl[0]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0100, 16'h0D00, 1'b1, 1'b0, 4'b0100, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd2, 1'b0, 1'b1};
    tbl[3]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0001, 16'h0006, 1'b0, 1'b0, 4'b0001, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0001, 16'h0006, 1'b0, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{4'b0001, 16'h0006, 1'b0, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd0, 1'b0, 1'b1};
    tbl[7]  = '{4'b0001, 16'h0006, 1'b0, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd0, 1'b0, 1'b1};
    tbl[8]  = '{4'b0001, 16'h0006, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd0, 1'b0, 1'b1};
    tbl[9]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{4'b0100, 16'h0D00, 1'b0, 1'b0, 4'b0100, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b1, 4'h9, 2'd2, 1'b0, 1'b1};
    tbl[12] = '{4'b1010, 16'h2010, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd1, 1'b0, 1'b1};
    tbl[14] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{4'b0010, 16'h0000, 1'b1, 1'b0, 4'b0010, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[16] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h0, 2'd1, 1'b0, 1'b1};
    tbl[17] = '{4'b0010, 16'h0030, 1'b1, 1'b0, 4'b0010, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[18] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1, CHK,  1'b1};
    tbl[19] = '{4'b0010, 16'h0000, 1'b1, 1'b0, 4'b0010, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[20] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h0, 2'd1, CHK,  1'b1};
    tbl[21] = '{4'b0010, 16'h0010, 1'b1, 1'b0, 4'b0010, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[22] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd1, 1'b0, 1'b1};
    tbl[23] = '{4'b0010, 16'h0010, 1'b1, 1'b0, 4'b0010, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[24] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd1, 1'b0, 1'b1};

    drive('0, '0, 1'b1, 1'b1);
    repeat (2) tick();

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].g, tbl[i].rr, tbl[i].r);
      expect_cycle($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_valid,
                   tbl[i].e_bin, tbl[i].e_id, tbl[i].e_err, tbl[i].d);
    end

    // All requesters valid from reset: grants 0,1,2,3,0,1, one every two cycles.
    ord    = '{0, 1, 2, 3, 0, 1};
    rr_bin = '{4'h1, 4'h2, 4'h5, 4'hA};
    drive('0, '0, 1'b1, 1'b1);
    tick();
    for (int j = 0; j < 6; j++) begin
      drive(4'b1111, 16'hF731, 1'b1, 1'b0);
      expect_cycle($sformatf("rr%0d.grant", j), 4'(1 << ord[j]), 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      expect_cycle($sformatf("rr%0d.rsp", j), 4'b0000, 1'b1, rr_bin[ord[j]],
                   IDW'(ord[j]), 1'b0, 1'b1);
    end

    drive('0, '0, 1'b1, 1'b1);
    tick();
    g = '0;
    for (int n = 0; n < 600; n++) begin
      v = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0:       g[i*W +: W] = g[i*W +: W];
          1, 2:    g[i*W +: W] = g[i*W +: W] ^ W'(1 << $urandom_range(0, W - 1));
          default: g[i*W +: W] = W'($urandom);
        endcase
      end
      drive(v, g, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      w = pick(req_valid, m_ptr);
      e_ready = (!rst && !m_busy && w >= 0) ? NREQ'(1 << w) : '0;
      expect_cycle($sformatf("rnd%0d", n), e_ready, m_busy, m_bin, IDW'(m_id), m_err, m_busy);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
